// File: rtl/polar64_pkg.sv
// Shared constants and golden functions for the 64-bit polar code with CRC-16 outer code.
// Used by both the encoder and the decoder so the frozen-set and CRC definitions cannot drift.
package polar64_pkg;

  localparam int K_DATA = 24;
  localparam int K_CRC  = 16;
  localparam int K_FRZ  = 24;
  localparam int N_CW   = 64;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Information set: all indices of Hamming weight >= 3 except 7 and 11, ascending.
  localparam logic [5:0] INFO_POS [0:39] = '{
    6'd13, 6'd14, 6'd15, 6'd19, 6'd21, 6'd22, 6'd23, 6'd25, 6'd26, 6'd27,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd35, 6'd37, 6'd38, 6'd39, 6'd41, 6'd42,
    6'd43, 6'd44, 6'd45, 6'd46, 6'd47, 6'd49, 6'd50, 6'd51, 6'd52, 6'd53,
    6'd54, 6'd55, 6'd56, 6'd57, 6'd58, 6'd59, 6'd60, 6'd61, 6'd62, 6'd63
  };

  localparam logic [5:0] FROZEN_POS [0:23] = '{
    6'd0,  6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd10, 6'd11, 6'd12, 6'd16, 6'd17, 6'd18, 6'd20, 6'd24, 6'd32, 6'd33,
    6'd34, 6'd36, 6'd40, 6'd48
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CRC   = 2'd1,
    ST_MAP   = 2'd2,
    ST_XFORM = 2'd3
  } enc_state_t;

  function automatic logic [15:0] crc16_ccitt24(input logic [23:0] data);
    logic [15:0] c;
    c = CRC_INIT;
    for (int b = 23; b >= 0; b--) begin
      if (c[15] ^ data[b]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [63:0] polar_transform64(input logic [63:0] u);
    logic [63:0] x;
    x = u;
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 64; i++) begin
        if (((i >> s) & 1) == 0) x[i] = x[i] ^ x[i + (1 << s)];
      end
    end
    return x;
  endfunction

endpackage

// File: rtl/polar64_crc16_serial.sv
// CRC-16-CCITT engine folding CRC_BPC message bits per clock, MSB first.
// clr preloads the CCITT init value; en folds din into the running remainder.
module polar64_crc16_serial
  import polar64_pkg::*;
#(
  parameter int CRC_BPC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [CRC_BPC-1:0] din,
  output logic [15:0]        crc
);

  logic [15:0] r_crc;
  logic [15:0] w_fold;

  always_comb begin
    w_fold = r_crc;
    for (int b = CRC_BPC - 1; b >= 0; b--) begin
      if (w_fold[15] ^ din[b]) w_fold = {w_fold[14:0], 1'b0} ^ CRC_POLY;
      else                     w_fold = {w_fold[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_crc <= '0;
    else if (clr) r_crc <= CRC_INIT;
    else if (en)  r_crc <= w_fold;
  end

  assign crc = r_crc;

endmodule

// File: rtl/polar64_crc16_encoder.sv
// CRC-aided polar encoder: 24 data bits + CRC-16 mapped onto a 64-bit polar codeword.
// state | meaning
// IDLE  | waiting for start; ready high
// CRC   | folding CRC_BPC data bits per cycle into the CRC
// MAP   | scattering data and CRC onto the information set
// XFORM | one butterfly stage per cycle, six stages
module polar64_crc16_encoder
  import polar64_pkg::*;
#(
  parameter int CRC_BPC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] data_in,
  output logic        ready,
  output logic        done,
  output logic [63:0] cw_out,
  output logic [15:0] crc_out
);

  localparam int         CRC_CYC      = K_DATA / CRC_BPC;
  localparam logic [4:0] CNT_CRC_LAST = 5'(CRC_CYC - 1);
  localparam logic [4:0] CNT_XF_LAST  = 5'd5;

  enc_state_t r_state, w_next;
  logic [4:0]  r_cnt;
  logic [23:0] r_data;
  logic [63:0] r_x;
  logic        r_done;
  logic [63:0] r_cw;
  logic [15:0] r_crc_out;

  logic [15:0]        w_crc;
  logic [23:0]        w_data_sh;
  logic [CRC_BPC-1:0] w_din;
  logic [63:0]        w_u;
  logic [63:0]        w_x_stage;
  logic               w_accept;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_data_sh = r_data << (int'(r_cnt) * CRC_BPC);
  assign w_din     = w_data_sh[23 -: CRC_BPC];

  polar64_crc16_serial #(.CRC_BPC(CRC_BPC)) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (r_state == ST_CRC),
    .din   (w_din),
    .crc   (w_crc)
  );

  always_comb begin
    w_u = '0;
    for (int k = 0; k < K_DATA; k++) w_u[INFO_POS[k]] = r_data[23 - k];
    for (int k = 0; k < K_CRC; k++)  w_u[INFO_POS[K_DATA + k]] = w_crc[15 - k];
  end

  // Stage s pairs i with i+2^s; the partner never changes within the stage.
  always_comb begin
    w_x_stage = r_x;
    for (int s = 0; s < 6; s++) begin
      if (r_cnt == 5'(s)) begin
        for (int i = 0; i < 64; i++) begin
          if (((i >> s) & 1) == 0) w_x_stage[i] = r_x[i] ^ r_x[i + (1 << s)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_CRC;
      ST_CRC:   if (r_cnt == CNT_CRC_LAST) w_next = ST_MAP;
      ST_MAP:   w_next = ST_XFORM;
      ST_XFORM: if (r_cnt == CNT_XF_LAST) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_x       <= '0;
      r_done    <= 1'b0;
      r_cw      <= '0;
      r_crc_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data <= data_in;
            r_cnt  <= '0;
          end
        end
        ST_CRC: begin
          r_cnt <= (r_cnt == CNT_CRC_LAST) ? 5'd0 : r_cnt + 5'd1;
        end
        ST_MAP: begin
          r_x   <= w_u;
          r_cnt <= '0;
        end
        ST_XFORM: begin
          r_x   <= w_x_stage;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == CNT_XF_LAST) begin
            r_cw      <= w_x_stage;
            r_crc_out <= w_crc;
            r_done    <= 1'b1;
            r_cnt     <= '0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign ready   = (r_state == ST_IDLE);
  assign done    = r_done;
  assign cw_out  = r_cw;
  assign crc_out = r_crc_out;

endmodule

// File: tb/tb_polar64_crc16_encoder.sv
// Scoreboard bench for the polar64 CRC-16 encoder with a matrix-form reference model.
// Stimulus pushes expected jobs; the done monitor pops and checks codeword, CRC and timing.
module tb_polar64_crc16_encoder;
  import polar64_pkg::*;

  localparam int BPC = 4;
  localparam int LAT = 24 / BPC + 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] data_in = '0;
  logic        ready, done;
  logic [63:0] cw_out;
  logic [15:0] crc_out;

  polar64_crc16_encoder #(.CRC_BPC(BPC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .ready   (ready),
    .done    (done),
    .cw_out  (cw_out),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_pushed = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // CRC as remainder of (M * x^16 + init * x^24) mod P.
  function automatic logic [15:0] model_crc(input logic [23:0] d);
    logic [39:0] v;
    v = {d, 16'h0000} ^ {16'hFFFF, 24'h000000};
    for (int b = 39; b >= 16; b--) if (v[b]) v = v ^ (40'h11021 << (b - 16));
    return v[15:0];
  endfunction

  function automatic logic [63:0] model_u(input logic [23:0] d, input logic [15:0] c);
    logic [63:0] u;
    u = '0;
    for (int k = 0; k < 24; k++) u[INFO_POS[k]] = d[23 - k];
    for (int k = 0; k < 16; k++) u[INFO_POS[24 + k]] = c[15 - k];
    return u;
  endfunction

  // Generator-matrix form: x[j] is the XOR of u[i] over every i whose bits cover j.
  function automatic logic [63:0] model_x(input logic [63:0] u);
    logic [63:0] x;
    for (int j = 0; j < 64; j++) begin
      logic p;
      p = 1'b0;
      for (int i = 0; i < 64; i++) if ((i & j) == j) p = p ^ u[i];
      x[j] = p;
    end
    return x;
  endfunction

  task automatic push_job(input logic [23:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      n_done++;
      check("done_single", 64'(prev_done), 64'd0);
      check("done_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t        e;
        logic [15:0] c;
        logic [63:0] uu;
        logic [23:0] rd;
        logic [15:0] rc;
        logic        frz;
        e  = sb.pop_front();
        c  = model_crc(e.data);
        check("cw", cw_out, model_x(model_u(e.data, c)));
        check("crc", 64'(crc_out), 64'(c));
        check("latency_cycle", 64'(cyc), 64'(e.due));
        uu  = model_x(cw_out);
        frz = 1'b0;
        for (int k = 0; k < 24; k++) rd[23 - k] = uu[INFO_POS[k]];
        for (int k = 0; k < 16; k++) rc[15 - k] = uu[INFO_POS[24 + k]];
        for (int f = 0; f < 24; f++) frz = frz | uu[FROZEN_POS[f]];
        check("roundtrip_data", 64'(rd), 64'(e.data));
        check("roundtrip_crc_valid", 64'(rc), 64'(model_crc(rd)));
        check("roundtrip_frozen", 64'(frz), 64'd0);
      end
    end
    prev_done = rst_n && done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lowcnt;
    int          next_acc;
    logic [23:0] d;
    logic [63:0] u;

    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_cw", cw_out, 64'd0);
    check("reset_crc", 64'(crc_out), 64'd0);

    d = 24'hA5C3F0;
    check("pkg_crc_fn", 64'(crc16_ccitt24(d)), 64'(model_crc(d)));
    u = model_u(d, model_crc(d));
    check("pkg_xform_fn", polar_transform64(u), model_x(u));
    check("xform_self_inverse", model_x(model_x(u)), u);

    // Release reset and start on the same negedge: first edge must accept.
    rst_n   = 1'b1;
    start   = 1'b1;
    data_in = 24'hA5C3F0;
    push_job(24'hA5C3F0, cyc + 1 + LAT);
    lowcnt = 0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin
        start   = 1'b1;
        data_in = 24'h123456;
      end
      if (k < LAT && !ready) lowcnt++;
    end
    check("ready_low_cycles", 64'(lowcnt), 64'(LAT));
    check("ready_after_done", 64'(ready), 64'd1);
    drain("drain_directed");

    for (int j = 0; j < 30; j++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d       = 24'($urandom);
      start   = 1'b1;
      data_in = d;
      push_job(d, cyc + 1 + LAT);
      for (int k = 0; k < LAT - 3; k++) begin
        @(negedge clk);
        start   = 1'($urandom);
        data_in = 24'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    end
    drain("drain_random");

    start    = 1'b1;
    next_acc = cyc + 1;
    while (n_pushed < 37) begin
      d       = 24'($urandom);
      data_in = d;
      if (cyc + 1 == next_acc) begin
        push_job(d, next_acc + LAT);
        next_acc = next_acc + LAT + 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain("drain_continuous");

    start   = 1'b1;
    data_in = 24'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ready", 64'(ready), 64'd1);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_cw", cw_out, 64'd0);
    check("midreset_crc", 64'(crc_out), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    start   = 1'b1;
    d       = 24'($urandom);
    data_in = d;
    push_job(d, cyc + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    drain("drain_after_reset");
    repeat (20) @(negedge clk);

    check("done_count", 64'(n_done), 64'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
